pet_scene_ctrl: RTL and testbench

//  Behaviour controller between sensor front-ends (gyro/touch/sonic/joystick) and screen renderer.

---
 rtl/pet_scene_ctrl.sv | 158 +++++++++++++++
 tb/tb_pet_scene_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pet_scene_ctrl.sv
// Pet behaviour controller: sensor edge detect, pet FSM, saturating mood, scene valid/ready issue.
// Optional PET_MOOD_DECAY_EN adds periodic mood decay outside SLEEP.
module pet_scene_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned WAKE_CYCLES    = 100_000_000,
  parameter int unsigned HAPPY_CYCLES   = 200_000_000,
  parameter int unsigned DECAY_CYCLES   = 1_000_000_000,
  parameter int unsigned MOOD_MAX       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       awaking,
  input  logic       touched,
  input  logic       expecting,
  input  logic       petting,
  input  logic       pressed,
  input  logic       up,
  input  logic       down,
  input  logic       scene_ready,
  output logic [2:0] scene,
  output logic       scene_valid,
  output logic [3:0] mood,
  output logic [1:0] menu_sel,
  output logic [2:0] state_dbg
);
  localparam int unsigned DWMAX = (WAKE_CYCLES > HAPPY_CYCLES) ? WAKE_CYCLES : HAPPY_CYCLES;
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(DWMAX + 1);

  typedef enum logic [2:0] {
    S_SLEEP = 3'd0, S_WAKE = 3'd1, S_IDLE = 3'd2,
    S_EXPECT = 3'd3, S_HAPPY = 3'd4, S_MENU = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      in_now, in_q, rise;
  logic [AW-1:0]   act_q;
  logic [DW-1:0]   dwell_q;
  logic [3:0]      mood_q, mood_d, mood_dn;
  logic [4:0]      mood_sum;
  logic [1:0]      sel_q, sel_d, mood_inc;
  logic            mood_dec, dwell_rst, decay_tick, state_chg, act_to;
  logic [2:0]      scene_q;
  logic            valid_q, dirty_q;

  // {down, up, pressed, petting, expecting, touched, awaking}
  assign in_now    = {down, up, pressed, petting, expecting, touched, awaking};
  assign rise      = in_now & ~in_q;
  assign state_chg = (state_d != state_q);
  assign act_to    = (act_q == AW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mood_inc  = 2'd0;
    mood_dec  = 1'b0;
    dwell_rst = 1'b0;
    case (state_q)
      S_SLEEP:  if (rise[0] || go) state_d = S_WAKE;
      S_WAKE:   if (go || dwell_q == DW'(WAKE_CYCLES - 1)) state_d = S_IDLE;
      S_IDLE: begin
        if (rise[4])      state_d = S_MENU;
        else if (rise[1]) begin state_d = S_HAPPY; mood_inc = 2'd1; end
        else if (rise[2]) state_d = S_EXPECT;
        else if (act_to)  begin state_d = S_SLEEP; mood_dec = 1'b1; end
      end
      S_EXPECT: begin
        if (rise[3])         begin state_d = S_HAPPY; mood_inc = 2'd2; end
        else if (!expecting) state_d = S_IDLE;
      end
      S_HAPPY: begin
        if (dwell_q == DW'(HAPPY_CYCLES - 1)) state_d = S_IDLE;
        else if (rise[1] || rise[3]) begin dwell_rst = 1'b1; mood_inc = 2'd1; end
      end
      S_MENU: begin
        if (rise[4] || go) state_d = S_IDLE;
        else if (rise[5])  sel_d = sel_q - 2'd1;
        else if (rise[6])  sel_d = sel_q + 2'd1;
        else if (act_to)   state_d = S_IDLE;
      end
      default: state_d = S_SLEEP;
    endcase
  end

  // 5-bit sum so a +2 near the ceiling clamps instead of wrapping
  assign mood_sum = {1'b0, mood_q} + {3'b000, mood_inc};
  assign mood_dn  = (mood_q == 4'd0) ? 4'd0 : mood_q - 4'd1;

  always_comb begin
    mood_d = mood_q;
    if (mood_inc != 2'd0)
      mood_d = (mood_sum > 5'(MOOD_MAX)) ? 4'(MOOD_MAX) : mood_sum[3:0];
    else if (mood_dec || decay_tick)
      mood_d = mood_dn;
  end

`ifdef PET_MOOD_DECAY_EN
  localparam int CW = $clog2(DECAY_CYCLES + 1);
  logic [CW-1:0] decay_q;
  assign decay_tick = (state_q != S_SLEEP) && (decay_q == CW'(DECAY_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst || mood_inc != 2'd0 || state_q == S_SLEEP || decay_tick) decay_q <= '0;
    else                                                             decay_q <= decay_q + 1'b1;
  end
`else
  assign decay_tick = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SLEEP;
      in_q    <= '0;
      act_q   <= '0;
      dwell_q <= '0;
      mood_q  <= 4'd8;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      in_q    <= in_now;
      mood_q  <= mood_d;
      sel_q   <= sel_d;
      if (state_chg || (|rise) || go)    act_q <= '0;
      else if (act_q != AW'(TIMEOUT_CYCLES)) act_q <= act_q + 1'b1;
      if (state_chg || dwell_rst)        dwell_q <= '0;
      else if ((state_q == S_WAKE || state_q == S_HAPPY) && dwell_q != DW'(DWMAX))
        dwell_q <= dwell_q + 1'b1;
    end
  end

  // Scene is frozen while stalled; only the latest state is re-issued afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q <= 3'd0;
      valid_q <= 1'b1;
      dirty_q <= 1'b0;
    end else if (valid_q) begin
      if (scene_ready) begin
        valid_q <= 1'b0;
        dirty_q <= state_chg;
      end else begin
        dirty_q <= dirty_q | state_chg;
      end
    end else if (dirty_q || state_q != scene_q) begin
      scene_q <= state_q;
      valid_q <= 1'b1;
      dirty_q <= state_chg;
    end else begin
      dirty_q <= 1'b0;
    end
  end

  assign scene       = scene_q;
  assign scene_valid = valid_q;
  assign mood        = mood_q;
  assign menu_sel    = sel_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_pet_scene_ctrl.sv
// Directed bench for pet_scene_ctrl: scene transfers scored against a queue of expected scene ids.
module tb_pet_scene_ctrl;
  logic       clk = 1'b0;
  logic       rst, go, awaking, touched, expecting, petting, pressed, up, down, scene_ready;
  logic [2:0] scene, state_dbg;
  logic       scene_valid;
  logic [3:0] mood;
  logic [1:0] menu_sel;

  int checks = 0;
  int errors = 0;
  int q[$];
  int sel_m;

  always #5 clk = ~clk;

  pet_scene_ctrl #(
    .TIMEOUT_CYCLES(100), .WAKE_CYCLES(10), .HAPPY_CYCLES(20),
    .DECAY_CYCLES(50), .MOOD_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .awaking(awaking), .touched(touched),
    .expecting(expecting), .petting(petting), .pressed(pressed), .up(up), .down(down),
    .scene_ready(scene_ready), .scene(scene), .scene_valid(scene_valid), .mood(mood),
    .menu_sel(menu_sel), .state_dbg(state_dbg)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every accepted scene must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && scene_valid === 1'b1 && scene_ready === 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL scene_xfer observed %0d expected none", scene);
      end
      if (q.size() != 0) begin
        int exp_s;
        exp_s = q.pop_front();
        assert (scene === 3'(exp_s)) else begin
          errors++;
          $error("FAIL scene_xfer observed %0d expected %0d", scene, exp_s);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; go = 1'b0; awaking = 1'b0; touched = 1'b0; expecting = 1'b0;
    petting = 1'b0; pressed = 1'b0; up = 1'b0; down = 1'b0; scene_ready = 1'b1;
    cyc(2);
    chk("rst_state", state_dbg, 0);
    chk("rst_scene", scene, 0);
    chk("rst_valid", scene_valid, 1);
    chk("rst_mood", mood, 8);
    chk("rst_sel", menu_sel, 0);
    q.push_back(0);
    rst = 1'b0;
    cyc(1);
    chk("valid_drop", scene_valid, 0);

    // SLEEP -> WAKE -> IDLE after dwell
    awaking = 1'b1; q.push_back(1); cyc(1); awaking = 1'b0;
    chk("wake_state", state_dbg, 1);
    cyc(1);
    chk("wake_scene", scene, 1);
    chk("wake_valid", scene_valid, 1);
    cyc(8);
    chk("wake_dwell", state_dbg, 1);
    q.push_back(2); cyc(1);
    chk("wake_to_idle", state_dbg, 2);

    // mood saturation through repeated touches
    q.push_back(4);
    for (int i = 0; i < 10; i++) begin
      touched = 1'b1; cyc(1); touched = 1'b0;
      chk("mood_sat", mood, (9 + i > 15) ? 15 : 9 + i);
      cyc(1);
    end
    chk("happy_state", state_dbg, 4);
    cyc(18);
    chk("happy_dwell", state_dbg, 4);
    q.push_back(2); cyc(1);
    chk("happy_to_idle", state_dbg, 2);

    // EXPECT -> HAPPY (+2 clamped) -> IDLE -> SLEEP on inactivity
    cyc(3);
    expecting = 1'b1; q.push_back(3); cyc(1);
    chk("expect_state", state_dbg, 3);
    cyc(3);
    petting = 1'b1; q.push_back(4); cyc(1); petting = 1'b0; expecting = 1'b0;
    chk("pet_state", state_dbg, 4);
    chk("pet_mood", mood, 15);
    cyc(19);
    chk("pet_dwell", state_dbg, 4);
    q.push_back(2); cyc(1);
    chk("pet_to_idle", state_dbg, 2);
    cyc(99);
    chk("idle_before_to", state_dbg, 2);
    q.push_back(0); cyc(1);
    chk("idle_timeout", state_dbg, 0);
    chk("timeout_mood", mood, 14);

    // menu navigation
    cyc(3);
    go = 1'b1; q.push_back(1); cyc(1); go = 1'b0;
    chk("go_wake", state_dbg, 1);
    cyc(3);
    go = 1'b1; q.push_back(2); cyc(1); go = 1'b0;
    chk("go_idle", state_dbg, 2);
    cyc(3);
    pressed = 1'b1; q.push_back(5); cyc(1); pressed = 1'b0;
    chk("menu_enter", state_dbg, 5);
    cyc(3);
    sel_m = 0;
    for (int i = 0; i < 5; i++) begin
      down = 1'b1; cyc(1); down = 1'b0;
      sel_m = (sel_m + 1) % 4;
      chk("menu_down", menu_sel, sel_m);
      cyc(1);
    end
    chk("menu_wrap", menu_sel, 1);
    up = 1'b1; down = 1'b1; cyc(1); up = 1'b0; down = 1'b0;
    chk("menu_up_wins", menu_sel, 0);
    chk("menu_stay", state_dbg, 5);
    cyc(1);
    pressed = 1'b1; q.push_back(2); cyc(1); pressed = 1'b0;
    chk("menu_exit", state_dbg, 2);
    cyc(3);
    pressed = 1'b1; q.push_back(5); cyc(1); pressed = 1'b0;
    chk("menu_reenter", state_dbg, 5);
    cyc(99);
    chk("menu_before_to", state_dbg, 5);
    q.push_back(2); cyc(1);
    chk("menu_timeout", state_dbg, 2);

    // back-pressure: intermediate states dropped, latest issued after release
    cyc(3);
    scene_ready = 1'b0;
    expecting = 1'b1; q.push_back(3); cyc(1);
    chk("bp_expect", state_dbg, 3);
    cyc(3);
    expecting = 1'b0; cyc(1);
    chk("bp_idle", state_dbg, 2);
    cyc(2);
    pressed = 1'b1; cyc(1); pressed = 1'b0;
    chk("bp_menu", state_dbg, 5);
    cyc(2);
    chk("bp_scene_held", scene, 3);
    chk("bp_valid_held", scene_valid, 1);
    q.push_back(5); scene_ready = 1'b1; cyc(1);
    chk("bp_valid_drop", scene_valid, 0);
    cyc(1);
    chk("bp_reissue_scene", scene, 5);
    chk("bp_reissue_valid", scene_valid, 1);
    cyc(2);

    // reset while a scene is stalled
    scene_ready = 1'b0;
    go = 1'b1; cyc(1); go = 1'b0;
    chk("rst6_idle", state_dbg, 2);
    cyc(2);
    chk("rst6_pending_valid", scene_valid, 1);
    chk("rst6_pending_scene", scene, 2);
    q.delete(); q.push_back(0);
    rst = 1'b1; cyc(1);
    chk("rst6_state", state_dbg, 0);
    chk("rst6_scene", scene, 0);
    chk("rst6_valid", scene_valid, 1);
    chk("rst6_mood", mood, 8);
    chk("rst6_sel", menu_sel, 0);
    rst = 1'b0; scene_ready = 1'b1;
    cyc(3);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
